// File: rtl/multicycle_control.sv
// Multicycle control FSM for a small LEGv8-style datapath (ADD/SUB/AND/ORR, LDUR/STUR, CBZ, B).
// Defining MC_CBNZ_EN adds CBNZ; otherwise its encoding decodes as illegal.
module multicycle_control (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [10:0] Opcode,
    input  logic        Zero,
    input  logic        MemReady,
    output logic [3:0]  ALUCtrl,
    output logic        Reg2Loc,
    output logic        ALUSrc,
    output logic        MemToReg,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        Illegal
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CL_NONE = 4'd0,
        CL_ADD  = 4'd1,
        CL_SUB  = 4'd2,
        CL_AND  = 4'd3,
        CL_ORR  = 4'd4,
        CL_LDUR = 4'd5,
        CL_STUR = 4'd6,
        CL_CBZ  = 4'd7,
        CL_CBNZ = 4'd8,
        CL_B    = 4'd9
    } class_t;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    state_t r_state;
    state_t w_nextState;
    class_t r_class;
    class_t w_decClass;
    logic   r_illegal;

    // R-type ALU operation; also reused in WB so the ALU result stays stable while it is written back.
    function automatic logic [3:0] aluOp(input class_t cls);
        case (cls)
            CL_SUB:  aluOp = ALU_SUB;
            CL_AND:  aluOp = ALU_AND;
            CL_ORR:  aluOp = ALU_OR;
            default: aluOp = ALU_ADD;
        endcase
    endfunction

    always_comb begin
        w_decClass = CL_NONE;
        casez (Opcode)
            11'b10001011000: w_decClass = CL_ADD;
            11'b11001011000: w_decClass = CL_SUB;
            11'b10001010000: w_decClass = CL_AND;
            11'b10101010000: w_decClass = CL_ORR;
            11'b11111000010: w_decClass = CL_LDUR;
            11'b11111000000: w_decClass = CL_STUR;
            11'b10110100???: w_decClass = CL_CBZ;
`ifdef MC_CBNZ_EN
            11'b10110101???: w_decClass = CL_CBNZ;
`endif
            11'b000101?????: w_decClass = CL_B;
            default:         w_decClass = CL_NONE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state   <= FETCH;
            r_class   <= CL_NONE;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (r_state == DECODE) begin
                r_class <= w_decClass;
            end
            if (w_nextState == HALT) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Reset overrides everything in the same cycle, so a MemWrite in flight is dropped immediately.
    always_comb begin
        w_nextState = r_state;
        ALUCtrl     = 4'b0000;
        Reg2Loc     = 1'b0;
        ALUSrc      = 1'b0;
        MemToReg    = 1'b0;
        RegWrite    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCSrc       = 1'b0;
        Illegal     = 1'b0;
        if (Reset) begin
            w_nextState = FETCH;
        end else begin
            Illegal = r_illegal;
            case (r_state)
                FETCH: begin
                    MemRead = 1'b1;
                    if (MemReady) begin
                        IRWrite     = 1'b1;
                        PCWrite     = 1'b1;
                        w_nextState = DECODE;
                    end
                end
                DECODE: begin
                    case (w_decClass)
                        CL_B: begin
                            PCWrite     = 1'b1;
                            PCSrc       = 1'b1;
                            w_nextState = FETCH;
                        end
                        CL_NONE: w_nextState = HALT;
                        default: w_nextState = EXEC;
                    endcase
                end
                EXEC: begin
                    case (r_class)
                        CL_ADD, CL_SUB, CL_AND, CL_ORR: begin
                            ALUCtrl     = aluOp(r_class);
                            w_nextState = WB;
                        end
                        CL_LDUR: begin
                            ALUCtrl     = ALU_ADD;
                            ALUSrc      = 1'b1;
                            w_nextState = MEM;
                        end
                        CL_STUR: begin
                            ALUCtrl     = ALU_ADD;
                            ALUSrc      = 1'b1;
                            Reg2Loc     = 1'b1;
                            w_nextState = MEM;
                        end
                        CL_CBZ: begin
                            ALUCtrl     = ALU_PASSB;
                            Reg2Loc     = 1'b1;
                            PCWrite     = Zero;
                            PCSrc       = 1'b1;
                            w_nextState = FETCH;
                        end
`ifdef MC_CBNZ_EN
                        CL_CBNZ: begin
                            ALUCtrl     = ALU_PASSB;
                            Reg2Loc     = 1'b1;
                            PCWrite     = ~Zero;
                            PCSrc       = 1'b1;
                            w_nextState = FETCH;
                        end
`endif
                        default: w_nextState = HALT;
                    endcase
                end
                MEM: begin
                    case (r_class)
                        CL_LDUR: begin
                            MemRead = 1'b1;
                            if (MemReady) begin
                                w_nextState = WB;
                            end
                        end
                        CL_STUR: begin
                            MemWrite = 1'b1;
                            if (MemReady) begin
                                w_nextState = FETCH;
                            end
                        end
                        default: w_nextState = HALT;
                    endcase
                end
                WB: begin
                    RegWrite    = 1'b1;
                    w_nextState = FETCH;
                    if (r_class == CL_LDUR) begin
                        MemToReg = 1'b1;
                        ALUCtrl  = ALU_ADD;
                        ALUSrc   = 1'b1;
                    end else begin
                        ALUCtrl  = aluOp(r_class);
                    end
                end
                HALT: begin
                    w_nextState = HALT;
                end
                default: begin
                    w_nextState = HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: one scenario task per instruction class / corner case.
// All control outputs are packed into one vector and compared per cycle against hand-built expectations.
module tb_multicycle_control;

    logic        CLK;
    logic        Reset;
    logic [10:0] Opcode;
    logic        Zero;
    logic        MemReady;
    logic [3:0]  ALUCtrl;
    logic        Reg2Loc, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite;
    logic        IRWrite, PCWrite, PCSrc, Illegal;

    int checks;
    int failures;

    typedef struct {
        logic        rst;
        logic        mr;
        logic        z;
        logic [13:0] exp;
    } step_t;

    multicycle_control dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .ALUCtrl(ALUCtrl), .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemToReg(MemToReg),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .Illegal(Illegal)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [13:0] w_outs;
    assign w_outs = {ALUCtrl, Reg2Loc, ALUSrc, MemToReg, RegWrite, MemRead,
                     MemWrite, IRWrite, PCWrite, PCSrc, Illegal};

    function automatic logic [13:0] mk(input logic [3:0] alu, input logic r2l, input logic asrc,
                                       input logic m2r, input logic rw, input logic mr,
                                       input logic mw, input logic irw, input logic pcw,
                                       input logic pcs, input logic ill);
        mk = {alu, r2l, asrc, m2r, rw, mr, mw, irw, pcw, pcs, ill};
    endfunction

    function automatic step_t st(input logic rst, input logic mr, input logic z, input logic [13:0] exp);
        st.rst = rst;
        st.mr  = mr;
        st.z   = z;
        st.exp = exp;
    endfunction

    logic [13:0] fZero, fFetchGo, fFetchIdle;

    task automatic test_reset();
        step_t seq[$];
        seq.push_back(st(1'b1, 1'b1, 1'b0, fZero));
        seq.push_back(st(1'b1, 1'b1, 1'b0, fZero));
        seq.push_back(st(1'b0, 1'b0, 1'b0, fFetchIdle));
        seq.push_back(st(1'b0, 1'b0, 1'b0, fFetchIdle));
        foreach (seq[i]) begin
            Reset = seq[i].rst; MemReady = seq[i].mr; Zero = seq[i].z; #1;
            checks++;
            if (w_outs !== seq[i].exp) begin
                failures++;
                $display("[TB] FAIL reset step%0d: got %b expected %b", i, w_outs, seq[i].exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_add();
        step_t seq[$];
        Opcode = 11'b10001011000;
        seq.push_back(st(1'b0, 1'b1, 1'b0, fFetchGo));
        seq.push_back(st(1'b0, 1'b1, 1'b0, fZero));
        seq.push_back(st(1'b0, 1'b1, 1'b0, mk(4'b0010,0,0,0,0,0,0,0,0,0,0)));
        seq.push_back(st(1'b0, 1'b1, 1'b0, mk(4'b0010,0,0,0,1,0,0,0,0,0,0)));
        seq.push_back(st(1'b0, 1'b0, 1'b0, fFetchIdle));
        foreach (seq[i]) begin
            Reset = seq[i].rst; MemReady = seq[i].mr; Zero = seq[i].z; #1;
            checks++;
            if (w_outs !== seq[i].exp) begin
                failures++;
                $display("[TB] FAIL add step%0d: got %b expected %b", i, w_outs, seq[i].exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_rtype_ops();
        logic [10:0] ops  [3] = '{11'b11001011000, 11'b10001010000, 11'b10101010000};
        logic [3:0]  alus [3] = '{4'b0110, 4'b0000, 4'b0001};
        for (int k = 0; k < 3; k++) begin
            step_t seq[$];
            Opcode = ops[k];
            seq.push_back(st(1'b0, 1'b1, 1'b0, fFetchGo));
            seq.push_back(st(1'b0, 1'b1, 1'b0, fZero));
            seq.push_back(st(1'b0, 1'b1, 1'b0, mk(alus[k],0,0,0,0,0,0,0,0,0,0)));
            seq.push_back(st(1'b0, 1'b1, 1'b0, mk(alus[k],0,0,0,1,0,0,0,0,0,0)));
            seq.push_back(st(1'b0, 1'b0, 1'b0, fFetchIdle));
            foreach (seq[i]) begin
                Reset = seq[i].rst; MemReady = seq[i].mr; Zero = seq[i].z; #1;
                checks++;
                if (w_outs !== seq[i].exp) begin
                    failures++;
                    $display("[TB] FAIL rtype op%0d step%0d: got %b expected %b", k, i, w_outs, seq[i].exp);
                end
                @(posedge CLK); #1;
            end
        end
    endtask

    task automatic test_ldur_wait();
        step_t seq[$];
        Opcode = 11'b11111000010;
        seq.push_back(st(1'b0, 1'b1, 1'b0, fFetchGo));
        seq.push_back(st(1'b0, 1'b0, 1'b0, fZero));
        seq.push_back(st(1'b0, 1'b0, 1'b0, mk(4'b0010,0,1,0,0,0,0,0,0,0,0)));
        seq.push_back(st(1'b0, 1'b0, 1'b0, mk(4'b0000,0,0,0,0,1,0,0,0,0,0)));
        seq.push_back(st(1'b0, 1'b0, 1'b0, mk(4'b0000,0,0,0,0,1,0,0,0,0,0)));
        seq.push_back(st(1'b0, 1'b1, 1'b0, mk(4'b0000,0,0,0,0,1,0,0,0,0,0)));
        seq.push_back(st(1'b0, 1'b0, 1'b0, mk(4'b0010,0,1,1,1,0,0,0,0,0,0)));
        seq.push_back(st(1'b0, 1'b0, 1'b0, fFetchIdle));
        foreach (seq[i]) begin
            Reset = seq[i].rst; MemReady = seq[i].mr; Zero = seq[i].z; #1;
            checks++;
            if (w_outs !== seq[i].exp) begin
                failures++;
                $display("[TB] FAIL ldur step%0d: got %b expected %b", i, w_outs, seq[i].exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_stur();
        step_t seq[$];
        Opcode = 11'b11111000000;
        seq.push_back(st(1'b0, 1'b1, 1'b0, fFetchGo));
        seq.push_back(st(1'b0, 1'b1, 1'b0, fZero));
        seq.push_back(st(1'b0, 1'b1, 1'b0, mk(4'b0010,1,1,0,0,0,0,0,0,0,0)));
        seq.push_back(st(1'b0, 1'b1, 1'b0, mk(4'b0000,0,0,0,0,0,1,0,0,0,0)));
        seq.push_back(st(1'b0, 1'b0, 1'b0, fFetchIdle));
        foreach (seq[i]) begin
            Reset = seq[i].rst; MemReady = seq[i].mr; Zero = seq[i].z; #1;
            checks++;
            if (w_outs !== seq[i].exp) begin
                failures++;
                $display("[TB] FAIL stur step%0d: got %b expected %b", i, w_outs, seq[i].exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_branch();
        step_t seq[$];
        Opcode = 11'b00010100110;
        seq.push_back(st(1'b0, 1'b1, 1'b0, fFetchGo));
        seq.push_back(st(1'b0, 1'b1, 1'b0, mk(4'b0000,0,0,0,0,0,0,0,1,1,0)));
        seq.push_back(st(1'b0, 1'b0, 1'b0, fFetchIdle));
        foreach (seq[i]) begin
            Reset = seq[i].rst; MemReady = seq[i].mr; Zero = seq[i].z; #1;
            checks++;
            if (w_outs !== seq[i].exp) begin
                failures++;
                $display("[TB] FAIL branch step%0d: got %b expected %b", i, w_outs, seq[i].exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_cbz();
        step_t seq[$];
        Opcode = 11'b10110100101;
        seq.push_back(st(1'b0, 1'b1, 1'b1, fFetchGo));
        seq.push_back(st(1'b0, 1'b1, 1'b1, fZero));
        seq.push_back(st(1'b0, 1'b1, 1'b1, mk(4'b0111,1,0,0,0,0,0,0,1,1,0)));
        seq.push_back(st(1'b0, 1'b1, 1'b0, fFetchGo));
        seq.push_back(st(1'b0, 1'b1, 1'b0, fZero));
        seq.push_back(st(1'b0, 1'b1, 1'b0, mk(4'b0111,1,0,0,0,0,0,0,0,1,0)));
        seq.push_back(st(1'b0, 1'b0, 1'b0, fFetchIdle));
        foreach (seq[i]) begin
            Reset = seq[i].rst; MemReady = seq[i].mr; Zero = seq[i].z; #1;
            checks++;
            if (w_outs !== seq[i].exp) begin
                failures++;
                $display("[TB] FAIL cbz step%0d: got %b expected %b", i, w_outs, seq[i].exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_illegal();
        step_t seq[$];
        Opcode = 11'b11111111111;
        seq.push_back(st(1'b0, 1'b1, 1'b0, fFetchGo));
        seq.push_back(st(1'b0, 1'b1, 1'b0, fZero));
        for (int n = 0; n < 10; n++) begin
            seq.push_back(st(1'b0, 1'b1, 1'b0, mk(4'b0000,0,0,0,0,0,0,0,0,0,1)));
        end
        seq.push_back(st(1'b1, 1'b1, 1'b0, fZero));
        seq.push_back(st(1'b0, 1'b0, 1'b0, fFetchIdle));
        foreach (seq[i]) begin
            Reset = seq[i].rst; MemReady = seq[i].mr; Zero = seq[i].z; #1;
            checks++;
            if (w_outs !== seq[i].exp) begin
                failures++;
                $display("[TB] FAIL illegal step%0d: got %b expected %b", i, w_outs, seq[i].exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_stur_reset();
        step_t seq[$];
        Opcode = 11'b11111000000;
        seq.push_back(st(1'b0, 1'b1, 1'b0, fFetchGo));
        seq.push_back(st(1'b0, 1'b0, 1'b0, fZero));
        seq.push_back(st(1'b0, 1'b0, 1'b0, mk(4'b0010,1,1,0,0,0,0,0,0,0,0)));
        seq.push_back(st(1'b0, 1'b0, 1'b0, mk(4'b0000,0,0,0,0,0,1,0,0,0,0)));
        seq.push_back(st(1'b1, 1'b0, 1'b0, fZero));
        seq.push_back(st(1'b0, 1'b0, 1'b0, fFetchIdle));
        foreach (seq[i]) begin
            Reset = seq[i].rst; MemReady = seq[i].mr; Zero = seq[i].z; #1;
            checks++;
            if (w_outs !== seq[i].exp) begin
                failures++;
                $display("[TB] FAIL stur_reset step%0d: got %b expected %b", i, w_outs, seq[i].exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_cbnz();
        step_t seq[$];
        Opcode = 11'b10110101011;
        seq.push_back(st(1'b0, 1'b1, 1'b0, fFetchGo));
        seq.push_back(st(1'b0, 1'b1, 1'b0, fZero));
`ifdef MC_CBNZ_EN
        seq.push_back(st(1'b0, 1'b1, 1'b0, mk(4'b0111,1,0,0,0,0,0,0,1,1,0)));
        seq.push_back(st(1'b0, 1'b1, 1'b1, fFetchGo));
        seq.push_back(st(1'b0, 1'b1, 1'b1, fZero));
        seq.push_back(st(1'b0, 1'b1, 1'b1, mk(4'b0111,1,0,0,0,0,0,0,0,1,0)));
`else
        seq.push_back(st(1'b0, 1'b1, 1'b0, mk(4'b0000,0,0,0,0,0,0,0,0,0,1)));
        seq.push_back(st(1'b0, 1'b1, 1'b0, mk(4'b0000,0,0,0,0,0,0,0,0,0,1)));
        seq.push_back(st(1'b1, 1'b1, 1'b0, fZero));
`endif
        seq.push_back(st(1'b0, 1'b0, 1'b0, fFetchIdle));
        foreach (seq[i]) begin
            Reset = seq[i].rst; MemReady = seq[i].mr; Zero = seq[i].z; #1;
            checks++;
            if (w_outs !== seq[i].exp) begin
                failures++;
                $display("[TB] FAIL cbnz step%0d: got %b expected %b", i, w_outs, seq[i].exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        fZero      = mk(4'b0000,0,0,0,0,0,0,0,0,0,0);
        fFetchGo   = mk(4'b0000,0,0,0,0,1,0,1,1,0,0);
        fFetchIdle = mk(4'b0000,0,0,0,0,1,0,0,0,0,0);
        Reset      = 1'b1;
        Opcode     = 11'b0;
        Zero       = 1'b0;
        MemReady   = 1'b0;
        test_reset();
        test_add();
        test_rtype_ops();
        test_ldur_wait();
        test_stur();
        test_branch();
        test_cbz();
        test_illegal();
        test_stur_reset();
        test_cbnz();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
